// File: rtl/reu_pkg.sv
// Shared types for the REU DMA sequencer: command encoding, FSM states
// and the default REU RAM address width.
package reu_pkg;

  localparam int REU_AW_DEFAULT = 19;

  typedef enum logic [1:0] {
    CMD_STASH  = 2'b00,
    CMD_FETCH  = 2'b01,
    CMD_SWAP   = 2'b10,
    CMD_VERIFY = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    XFER    = 3'd1,
    SWAP_RD = 3'd2,
    SWAP_WR = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/dma_addr_counter.sv
// Loadable address counter with fix (hold) control and natural wrap at 2^W.
module dma_addr_counter
  import reu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic         fix_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && !fix_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dma_sequencer.sv
// REU DMA sequencer: stash / fetch / swap / verify between C64 bus and REU RAM.
// Define REU_VERIFY_EN to enable the verify command; otherwise 11 ends at once.
module dma_sequencer
  import reu_pkg::*;
#(
  parameter int REU_AW = REU_AW_DEFAULT
) (
  input  logic              PHI2,
  input  logic              Reset,
  input  logic              Execute,
  input  logic [1:0]        Command,
  input  logic [15:0]       C64AddrInit,
  input  logic [REU_AW-1:0] REUAddrInit,
  input  logic [15:0]       LengthInit,
  input  logic              Autoload,
  input  logic              C64AddrFix,
  input  logic              REUAddrFix,
  input  logic              IRQEnable,
  input  logic              StatusClear,
  input  logic              BA,
  input  logic [7:0]        C64DIn,
  output logic [7:0]        C64DOut,
  input  logic [7:0]        RAMDIn,
  output logic [7:0]        RAMDOut,
  output logic [REU_AW-1:0] RA,
  output logic              RAMWE,
  output logic              DMA,
  output logic              DMARW,
  output logic [15:0]       CA,
  output logic [15:0]       C64AddrCur,
  output logic [REU_AW-1:0] REUAddrCur,
  output logic [15:0]       LengthCur,
  output logic              Busy,
  output logic              EndOfBlock,
  output logic              Fault,
  output logic              IRQ
);

  state_e      state_q;
  cmd_e        cmd_q;
  logic [15:0] len_q;
  logic [7:0]  c64_hold_q, ram_hold_q;
  logic        dma_q, eob_q, fault_q;

  logic byte_done, last_byte, mismatch, load_cnt;

  // A byte completes on the final BA=1 cycle of its access pattern.
  assign byte_done = BA && (state_q == XFER || state_q == SWAP_WR);
  assign last_byte = (len_q == 16'd1);
  assign mismatch  = (cmd_q == CMD_VERIFY) && (C64DIn != RAMDIn);
  assign load_cnt  = (state_q == IDLE && Execute) || (state_q == DONE && Autoload);

  dma_addr_counter #(.W(16)) u_c64_cnt (
    .clk_i      (PHI2),
    .rst_i      (Reset),
    .load_i     (load_cnt),
    .load_val_i (C64AddrInit),
    .inc_i      (byte_done),
    .fix_i      (C64AddrFix),
    .cnt_o      (C64AddrCur)
  );

  dma_addr_counter #(.W(REU_AW)) u_reu_cnt (
    .clk_i      (PHI2),
    .rst_i      (Reset),
    .load_i     (load_cnt),
    .load_val_i (REUAddrInit),
    .inc_i      (byte_done),
    .fix_i      (REUAddrFix),
    .cnt_o      (REUAddrCur)
  );

  always_ff @(posedge PHI2 or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cmd_q      <= CMD_STASH;
      len_q      <= '0;
      c64_hold_q <= '0;
      ram_hold_q <= '0;
      dma_q      <= 1'b0;
      eob_q      <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      // Clear first so a set later in this block wins in the same cycle.
      if (StatusClear) begin
        eob_q   <= 1'b0;
        fault_q <= 1'b0;
      end
      if (load_cnt) begin
        len_q <= LengthInit;
      end
      case (state_q)
        IDLE: begin
          if (Execute) begin
            cmd_q <= cmd_e'(Command);
            case (cmd_e'(Command))
              CMD_SWAP: begin
                state_q <= SWAP_RD;
                dma_q   <= 1'b1;
              end
`ifdef REU_VERIFY_EN
              default: begin
                state_q <= XFER;
                dma_q   <= 1'b1;
              end
`else
              CMD_VERIFY: begin
                state_q <= DONE;
                eob_q   <= 1'b1;
              end
              default: begin
                state_q <= XFER;
                dma_q   <= 1'b1;
              end
`endif
            endcase
          end
        end
        XFER, SWAP_WR: begin
          if (BA) begin
            if (last_byte) begin
              eob_q <= 1'b1;
            end else begin
              len_q <= len_q - 16'd1;
            end
            if (mismatch) begin
              fault_q <= 1'b1;
            end
            if (last_byte || mismatch) begin
              state_q <= DONE;
              dma_q   <= 1'b0;
            end else if (state_q == SWAP_WR) begin
              state_q <= SWAP_RD;
            end
          end
        end
        SWAP_RD: begin
          if (BA) begin
            c64_hold_q <= C64DIn;
            ram_hold_q <= RAMDIn;
            state_q    <= SWAP_WR;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    DMARW   = 1'b0;
    C64DOut = 8'h00;
    RAMDOut = 8'h00;
    case (state_q)
      XFER: begin
        DMARW = (cmd_q != CMD_FETCH);
        if (cmd_q == CMD_FETCH) C64DOut = RAMDIn;
        if (cmd_q == CMD_STASH) RAMDOut = C64DIn;
      end
      SWAP_RD: DMARW = 1'b1;
      SWAP_WR: begin
        C64DOut = ram_hold_q;
        RAMDOut = c64_hold_q;
      end
      default: DMARW = 1'b0;
    endcase
  end

  assign RAMWE      = BA && ((state_q == XFER && cmd_q == CMD_STASH) || state_q == SWAP_WR);
  assign DMA        = dma_q;
  assign Busy       = dma_q;
  assign CA         = C64AddrCur;
  assign RA         = REUAddrCur;
  assign LengthCur  = len_q;
  assign EndOfBlock = eob_q;
  assign Fault      = fault_q;
  assign IRQ        = IRQEnable && (eob_q || fault_q);

endmodule

// File: tb/tb_dma_sequencer.sv
// Randomized bench for dma_sequencer: behavioural memory model plus C64/REU
// memory emulation; define REU_VERIFY_EN to match a verify-enabled build.
module tb_dma_sequencer;

  localparam int AW = 19;

  logic          PHI2 = 1'b0;
  logic          Reset, Execute;
  logic [1:0]    Command;
  logic [15:0]   C64AddrInit, LengthInit;
  logic [AW-1:0] REUAddrInit;
  logic          Autoload, C64AddrFix, REUAddrFix, IRQEnable, StatusClear, BA;
  logic [7:0]    C64DIn, C64DOut, RAMDIn, RAMDOut;
  logic [AW-1:0] RA, REUAddrCur;
  logic          RAMWE, DMA, DMARW, Busy, EndOfBlock, Fault, IRQ;
  logic [15:0]   CA, C64AddrCur, LengthCur;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] c64_mem [0:65535];
  logic [7:0] ram_mem [0:(1<<AW)-1];
  logic [7:0] exp_c64 [0:65535];
  logic [7:0] exp_ram [0:(1<<AW)-1];

  dma_sequencer #(.REU_AW(AW)) dut (
    .PHI2(PHI2), .Reset(Reset), .Execute(Execute), .Command(Command),
    .C64AddrInit(C64AddrInit), .REUAddrInit(REUAddrInit), .LengthInit(LengthInit),
    .Autoload(Autoload), .C64AddrFix(C64AddrFix), .REUAddrFix(REUAddrFix),
    .IRQEnable(IRQEnable), .StatusClear(StatusClear), .BA(BA),
    .C64DIn(C64DIn), .C64DOut(C64DOut), .RAMDIn(RAMDIn), .RAMDOut(RAMDOut),
    .RA(RA), .RAMWE(RAMWE), .DMA(DMA), .DMARW(DMARW), .CA(CA),
    .C64AddrCur(C64AddrCur), .REUAddrCur(REUAddrCur), .LengthCur(LengthCur),
    .Busy(Busy), .EndOfBlock(EndOfBlock), .Fault(Fault), .IRQ(IRQ)
  );

  // clock / reset
  always #5 PHI2 = ~PHI2;

  // memory emulation for both buses
  assign C64DIn = c64_mem[CA];
  assign RAMDIn = ram_mem[RA];

  always @(posedge PHI2) begin
    if (!Reset) begin
      if (RAMWE) ram_mem[RA] <= RAMDOut;
      if (DMA && BA && !DMARW) c64_mem[CA] <= C64DOut;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_c64(input logic [15:0] a, input logic [7:0] v);
    c64_mem[a] = v;
    exp_c64[a] = v;
  endtask

  task automatic set_ram(input logic [AW-1:0] a, input logic [7:0] v);
    ram_mem[a] = v;
    exp_ram[a] = v;
  endtask

  // Reference: apply the command byte by byte to the shadow memories.
  task automatic apply_model(input logic [1:0] cmd, input logic [15:0] ca0,
                             input logic [AW-1:0] ra0, input int n, input bit cfix,
                             input bit rfix, output int m, output bit flt);
    logic [15:0] c;
    logic [AW-1:0] r;
    logic [7:0] t;
    m = n;
    flt = 1'b0;
    for (int k = 0; k < n; k++) begin
      c = cfix ? ca0 : 16'(ca0 + k);
      r = rfix ? ra0 : AW'(ra0 + k);
      case (cmd)
        2'b00: exp_ram[r] = exp_c64[c];
        2'b01: exp_c64[c] = exp_ram[r];
        2'b10: begin t = exp_c64[c]; exp_c64[c] = exp_ram[r]; exp_ram[r] = t; end
        default: begin
          if (exp_c64[c] != exp_ram[r]) begin
            flt = 1'b1;
            m = k + 1;
            break;
          end
        end
      endcase
    end
  endtask

  // driver: one full command from IDLE through DONE and back to IDLE
  task automatic run_xfer(input string tag, input logic [1:0] cmd, input logic [15:0] ca0,
                          input logic [AW-1:0] ra0, input logic [15:0] len0,
                          input bit cfix, input bit rfix, input bit aload, input bit irqen,
                          input int stall_pct, input int stall_at, input int stall_len,
                          input bit hold_clr, output int dcyc);
    int n, m, stalls, cyc, budget, per;
    bit flt, no_dma;
    logic [15:0] ca_obs[$];
    logic [AW-1:0] ra_obs[$];
    logic [15:0] c, c_fin, len_e;
    logic [AW-1:0] r, r_fin;
    logic eob_e;
    n = (len0 == 16'd0) ? 65536 : int'(len0);
`ifdef REU_VERIFY_EN
    no_dma = 1'b0;
`else
    no_dma = (cmd == 2'b11);
`endif
    if (no_dma) begin
      m = 0;
      flt = 1'b0;
    end else begin
      apply_model(cmd, ca0, ra0, n, cfix, rfix, m, flt);
    end
    Command = cmd; C64AddrInit = ca0; REUAddrInit = ra0; LengthInit = len0;
    C64AddrFix = cfix; REUAddrFix = rfix; Autoload = aload; IRQEnable = irqen;
    StatusClear = hold_clr; BA = 1'b1; Execute = 1'b1;
    @(negedge PHI2);
    Execute = 1'b0;
    if (!no_dma) check_eq({tag, "_busy"}, Busy, 1'b1);
    stalls = 0; cyc = 0; budget = 2 * n + 100;
    while (DMA === 1'b1 && cyc < budget) begin
      BA = !((cyc >= stall_at && cyc < stall_at + stall_len) ||
             ($urandom_range(99) < stall_pct));
      if (!BA) stalls++;
      else if (cmd == 2'b01 || DMARW) begin
        ca_obs.push_back(CA);
        ra_obs.push_back(RA);
      end
      cyc++;
      @(negedge PHI2);
    end
    BA = 1'b1;
    dcyc = cyc;
    per = (cmd == 2'b10) ? 2 : 1;
    check_eq({tag, "_dma_off"}, DMA, 1'b0);
    check_eq({tag, "_busy_off"}, Busy, 1'b0);
    check_eq({tag, "_dma_cycles"}, cyc, m * per + stalls);
    check_eq({tag, "_nbytes"}, ca_obs.size(), m);
    for (int k = 0; k < m && k < 32 && k < ca_obs.size(); k++) begin
      c = cfix ? ca0 : 16'(ca0 + k);
      r = rfix ? ra0 : AW'(ra0 + k);
      check_eq({tag, "_ca_seq"}, ca_obs[k], c);
      check_eq({tag, "_ra_seq"}, ra_obs[k], r);
    end
    c_fin = cfix ? ca0 : 16'(ca0 + m);
    r_fin = rfix ? ra0 : AW'(ra0 + m);
    len_e = no_dma ? len0 : ((m == n) ? 16'd1 : 16'(n - m));
    eob_e = no_dma || (m == n);
    check_eq({tag, "_c64cur"}, C64AddrCur, c_fin);
    check_eq({tag, "_reucur"}, REUAddrCur, r_fin);
    check_eq({tag, "_lencur"}, LengthCur, len_e);
    check_eq({tag, "_eob"}, EndOfBlock, eob_e);
    check_eq({tag, "_fault"}, Fault, flt);
    check_eq({tag, "_irq"}, IRQ, irqen & (eob_e | flt));
    for (int k = 0; k < m; k++) begin
      if (n <= 64 || k < 32 || k % 4096 == 0 || k >= m - 4) begin
        c = cfix ? ca0 : 16'(ca0 + k);
        r = rfix ? ra0 : AW'(ra0 + k);
        check_eq({tag, "_c64mem"}, c64_mem[c], exp_c64[c]);
        check_eq({tag, "_rammem"}, ram_mem[r], exp_ram[r]);
      end
    end
    @(negedge PHI2);
    check_eq({tag, "_idle_c64"}, C64AddrCur, aload ? ca0 : c_fin);
    check_eq({tag, "_idle_reu"}, REUAddrCur, aload ? ra0 : r_fin);
    check_eq({tag, "_idle_len"}, LengthCur, aload ? len0 : len_e);
    check_eq({tag, "_sticky_eob"}, EndOfBlock, hold_clr ? 1'b0 : eob_e);
    StatusClear = 1'b1;
    @(negedge PHI2);
    StatusClear = 1'b0;
    check_eq({tag, "_clr_irq"}, IRQ, 1'b0);
  endtask

  initial begin
    int d;
    Reset = 1'b1; Execute = 1'b0; Command = 2'b00; C64AddrInit = '0; REUAddrInit = '0;
    LengthInit = '0; Autoload = 1'b0; C64AddrFix = 1'b0; REUAddrFix = 1'b0;
    IRQEnable = 1'b0; StatusClear = 1'b0; BA = 1'b1;
    for (int i = 0; i < 65536; i++) set_c64(16'(i), 8'($urandom));
    for (int i = 0; i < (1 << AW); i++) set_ram(AW'(i), 8'($urandom));
    repeat (2) @(negedge PHI2);
    check_eq("rst_dma", DMA, 1'b0);
    check_eq("rst_busy", Busy, 1'b0);
    check_eq("rst_ramwe", RAMWE, 1'b0);
    check_eq("rst_flags", {EndOfBlock, Fault, IRQ}, 3'b000);
    check_eq("rst_cnt", {C64AddrCur, LengthCur}, 32'h0);
    check_eq("rst_reu", REUAddrCur, '0);
    Reset = 1'b0;
    @(negedge PHI2);

    run_xfer("stash4", 2'b00, 16'h1000, '0, 16'd4, 0, 0, 0, 0, 0, -1, 0, 0, d);
    run_xfer("fetch_stall", 2'b01, 16'h2100, 19'h1_0200, 16'd3, 0, 0, 0, 1, 0, 1, 2, 0, d);
    check_eq("fetch_dma5", d, 5);

    set_c64(16'h3000, 8'h55);
    set_ram(19'h00700, 8'hAA);
    run_xfer("swap1", 2'b10, 16'h3000, 19'h00700, 16'd1, 0, 0, 0, 0, 0, -1, 0, 0, d);
    check_eq("swap_dma2", d, 2);
    check_eq("swap_c64", c64_mem[16'h3000], 8'hAA);
    check_eq("swap_ram", ram_mem[19'h00700], 8'h55);

`ifdef REU_VERIFY_EN
    set_ram(19'h00500, c64_mem[16'h4000]);
    set_ram(19'h00501, ~c64_mem[16'h4001]);
    run_xfer("verify", 2'b11, 16'h4000, 19'h00500, 16'd4, 0, 0, 0, 1, 0, -1, 0, 0, d);
`else
    run_xfer("verify_off", 2'b11, 16'h4000, 19'h00500, 16'd4, 0, 0, 0, 1, 0, -1, 0, 0, d);
    check_eq("verify_off_nodma", d, 0);
`endif

    run_xfer("wrap", 2'b01, 16'hFFFF, 19'h00123, 16'd2, 0, 1, 0, 0, 0, -1, 0, 0, d);
    run_xfer("setclr_aload", 2'b00, 16'h5000, 19'h7FFFE, 16'd3, 0, 0, 1, 1, 0, -1, 0, 1, d);

    for (int i = 0; i < 20; i++) begin
      run_xfer("rnd", 2'($urandom_range(2)), 16'($urandom), AW'($urandom),
               16'($urandom_range(12, 1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
               1'($urandom_range(1)), 1'($urandom_range(1)), 25, -1, 0,
               1'($urandom_range(1)), d);
    end

    // reset in the middle of a stash whose data already matches RAM
    for (int k = 0; k < 8; k++) set_ram(AW'(19'h00300 + k), c64_mem[16'h2000 + 16'(k)]);
    Command = 2'b00; C64AddrInit = 16'h2000; REUAddrInit = 19'h00300; LengthInit = 16'd8;
    C64AddrFix = 1'b0; REUAddrFix = 1'b0; Autoload = 1'b0; BA = 1'b1; Execute = 1'b1;
    @(negedge PHI2);
    Execute = 1'b0;
    repeat (2) @(negedge PHI2);
    check_eq("pre_rst_ramwe", RAMWE, 1'b1);
    check_eq("pre_rst_dma", DMA, 1'b1);
    Reset = 1'b1;
    #1;
    check_eq("midrst_dma", DMA, 1'b0);
    check_eq("midrst_ramwe", RAMWE, 1'b0);
    check_eq("midrst_busy", Busy, 1'b0);
    check_eq("midrst_cnt", {C64AddrCur, LengthCur}, 32'h0);
    @(negedge PHI2);
    Reset = 1'b0;
    @(negedge PHI2);

    run_xfer("len64k", 2'b00, 16'($urandom), 19'h10000, 16'd0, 0, 0, 0, 1, 0, -1, 0, 0, d);
    check_eq("len64k_cycles", d, 65536);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
